// File: rtl/rv_defs.sv
// Shared definitions for the machine-mode trap/interrupt controller:
// CSR addresses, cause codes, mstatus bit positions and the trap state type.
package rv_defs;

    localparam logic [11:0] CSR_MSTATUS = 12'h300;
    localparam logic [11:0] CSR_MIE     = 12'h304;
    localparam logic [11:0] CSR_MEPC    = 12'h341;
    localparam logic [11:0] CSR_MCAUSE  = 12'h342;
    localparam logic [11:0] CSR_MIP     = 12'h344;

    localparam logic [31:0] CAUSE_ILLEGAL   = 32'd2;
    localparam logic [31:0] CAUSE_BREAK     = 32'd3;
    localparam logic [31:0] CAUSE_UNAL_LOAD = 32'd4;
    localparam logic [31:0] CAUSE_UNAL_STOR = 32'd6;

    localparam int MSTATUS_MIE_BIT  = 3;
    localparam int MSTATUS_MPIE_BIT = 7;
    localparam int IRQ_BIT_BASE     = 16;

    typedef enum logic {
        ST_IDLE,
        ST_IN_TRAP
    } trap_state_e;

    // Interrupt cause: top bit flags an interrupt, code is 16 + line index
    function automatic logic [31:0] irq_cause(input logic [4:0] k);
        return {1'b1, 31'(IRQ_BIT_BASE + int'(k))};
    endfunction

endpackage

// File: rtl/rv_irq_sync.sv
// N-wide two-flop synchronizer for external interrupt lines, with a
// rising-edge strobe that lines up with the synchronized output rising.
module rv_irq_sync #(
    parameter int N = 8
) (
    input  logic         clk_i,
    input  logic         rst_n_i,
    input  logic [N-1:0] irq_i,
    output logic [N-1:0] sync_o,
    output logic [N-1:0] rise_o
);

    logic [N-1:0] s1_q;
    logic [N-1:0] s2_q;

    // Two-stage synchronizer chain
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            s1_q <= '0;
            s2_q <= '0;
        end else begin
            s1_q <= irq_i;
            s2_q <= s1_q;
        end
    end

    assign sync_o = s2_q;
    // Strobe is high in the cycle before sync_o goes 0->1, so a latch
    // clocked by it sets on the same edge the synchronized line rises.
    assign rise_o = s1_q & ~s2_q;

endmodule

// File: rtl/rv_irq_ctrl.sv
// Machine-mode trap controller: sync exceptions, N_IRQ external interrupts,
// mstatus/mie/mip/mepc/mcause CSRs. Define URV_IRQ_VECTORED_EN for vectored IRQs.
module rv_irq_ctrl
    import rv_defs::*;
#(
    parameter int               N_IRQ       = 8,
    parameter logic [N_IRQ-1:0] IRQ_EDGE    = '0,
    parameter logic [31:0]      VECTOR_BASE = 32'h8
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    input  logic             x_stall_i,
    input  logic             x_kill_i,
    input  logic             d_is_csr_i,
    input  logic             d_is_eret_i,
    input  logic [11:0]      d_csr_sel_i,
    input  logic [31:0]      x_csr_write_value_i,
    input  logic             exp_invalid_insn_i,
    input  logic             exp_breakpoint_i,
    input  logic             exp_unaligned_load_i,
    input  logic             exp_unaligned_store_i,
    input  logic [N_IRQ-1:0] irq_i,
    input  logic [31:0]      x_exception_pc_i,
    output logic             x_exception_o,
    output logic [31:0]      x_exception_pc_o,
    output logic [31:0]      x_exception_vector_o,
    output logic [31:0]      csr_mstatus_o,
    output logic [31:0]      csr_mie_o,
    output logic [31:0]      csr_mip_o,
    output logic [31:0]      csr_mepc_o,
    output logic [31:0]      csr_mcause_o
);

    trap_state_e      state_q, state_d;
    logic             mstat_mie_q, mstat_mie_d;
    logic             mstat_mpie_q, mstat_mpie_d;
    logic [N_IRQ-1:0] mie_q, mie_d;
    logic [N_IRQ-1:0] mip_edge_q, mip_edge_d;
    logic [29:0]      mepc_q, mepc_d;
    logic [31:0]      mcause_q, mcause_d;

    logic [N_IRQ-1:0] irq_sync, irq_rise, mip, pending, mip_clr;
    logic             advance, csr_wr, eret_adv, take_trap;
    logic             sync_exc, trap_req, irq_hit;
    logic [4:0]       irq_idx;
    logic [31:0]      cause;
    logic [31:0]      wdata;

    rv_irq_sync #(.N(N_IRQ)) u_sync (
        .clk_i   (clk_i),
        .rst_n_i (rst_n_i),
        .irq_i   (irq_i),
        .sync_o  (irq_sync),
        .rise_o  (irq_rise)
    );

    assign wdata     = x_csr_write_value_i;
    assign advance   = !x_stall_i && !x_kill_i;
    assign csr_wr    = advance && d_is_csr_i;
    assign eret_adv  = advance && d_is_eret_i;
    assign mip       = (IRQ_EDGE & mip_edge_q) | (~IRQ_EDGE & irq_sync);
    assign pending   = mip & mie_q;
    assign sync_exc  = exp_invalid_insn_i | exp_breakpoint_i
                     | exp_unaligned_load_i | exp_unaligned_store_i;
    assign trap_req  = sync_exc || (mstat_mie_q && |pending);
    assign x_exception_o = rst_n_i && (state_q == ST_IDLE) && trap_req;
    assign take_trap = advance && x_exception_o;
    assign mip_clr   = (csr_wr && d_csr_sel_i == CSR_MIP)
                     ? ~wdata[IRQ_BIT_BASE +: N_IRQ] : '0;

    // Lowest-numbered pending and enabled interrupt line
    always_comb begin
        irq_hit = 1'b0;
        irq_idx = '0;
        for (int k = N_IRQ - 1; k >= 0; k--) begin
            if (pending[k]) begin
                irq_hit = 1'b1;
                irq_idx = 5'(k);
            end
        end
    end

    // Fixed-priority trap cause
    always_comb begin
        if (exp_invalid_insn_i)         cause = CAUSE_ILLEGAL;
        else if (exp_breakpoint_i)      cause = CAUSE_BREAK;
        else if (exp_unaligned_load_i)  cause = CAUSE_UNAL_LOAD;
        else if (exp_unaligned_store_i) cause = CAUSE_UNAL_STOR;
        else if (irq_hit)               cause = irq_cause(irq_idx);
        else                            cause = '0;
    end

    // Trap state register
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) state_q <= ST_IDLE;
        else          state_q <= state_d;
    end

    // Trap state transitions
    always_comb begin
        state_d = state_q;
        if (take_trap)     state_d = ST_IN_TRAP;
        else if (eret_adv) state_d = ST_IDLE;
    end

    // CSR next-state: trap beats ERET beats CSR write for mstatus/mepc/mcause
    always_comb begin
        mstat_mie_d  = mstat_mie_q;
        mstat_mpie_d = mstat_mpie_q;
        mie_d        = mie_q;
        mepc_d       = mepc_q;
        mcause_d     = mcause_q;
        mip_edge_d   = IRQ_EDGE & (irq_rise | (mip_edge_q & ~mip_clr));
        if (csr_wr && d_csr_sel_i == CSR_MIE)
            mie_d = wdata[IRQ_BIT_BASE +: N_IRQ];
        if (take_trap) begin
            mepc_d       = x_exception_pc_i[31:2];
            mcause_d     = cause;
            mstat_mpie_d = mstat_mie_q;
            mstat_mie_d  = 1'b0;
        end else if (eret_adv) begin
            mstat_mie_d  = mstat_mpie_q;
            mstat_mpie_d = 1'b1;
        end else if (csr_wr) begin
            if (d_csr_sel_i == CSR_MSTATUS) begin
                mstat_mie_d  = wdata[MSTATUS_MIE_BIT];
                mstat_mpie_d = wdata[MSTATUS_MPIE_BIT];
            end
            if (d_csr_sel_i == CSR_MEPC)   mepc_d   = wdata[31:2];
            if (d_csr_sel_i == CSR_MCAUSE) mcause_d = wdata;
        end
    end

    // CSR registers
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            mstat_mie_q  <= 1'b0;
            mstat_mpie_q <= 1'b0;
            mie_q        <= '0;
            mip_edge_q   <= '0;
            mepc_q       <= '0;
            mcause_q     <= '0;
        end else begin
            mstat_mie_q  <= mstat_mie_d;
            mstat_mpie_q <= mstat_mpie_d;
            mie_q        <= mie_d;
            mip_edge_q   <= mip_edge_d;
            mepc_q       <= mepc_d;
            mcause_q     <= mcause_d;
        end
    end

    // CSR read views
    always_comb begin
        csr_mstatus_o = '0;
        csr_mie_o     = '0;
        csr_mip_o     = '0;
        csr_mstatus_o[MSTATUS_MIE_BIT]  = mstat_mie_q;
        csr_mstatus_o[MSTATUS_MPIE_BIT] = mstat_mpie_q;
        csr_mie_o[IRQ_BIT_BASE +: N_IRQ] = mie_q;
        csr_mip_o[IRQ_BIT_BASE +: N_IRQ] = mip;
    end

    assign csr_mepc_o       = {mepc_q, 2'b00};
    assign csr_mcause_o     = mcause_q;
    assign x_exception_pc_o = {mepc_q, 2'b00};

`ifdef URV_IRQ_VECTORED_EN
    assign x_exception_vector_o = (sync_exc || !irq_hit) ? VECTOR_BASE
        : VECTOR_BASE + ((32'(irq_idx) + 32'd1) << 2);
`else
    assign x_exception_vector_o = VECTOR_BASE;
`endif

endmodule

// File: tb/tb_rv_irq_ctrl.sv
// Scoreboard bench for rv_irq_ctrl: random and directed stimulus,
// expectations from a behavioural model, checked by a negedge monitor.
module tb_rv_irq_ctrl;

    localparam int          N    = 8;
    localparam logic [7:0]  EDGE = 8'b0100_0100;
    localparam logic [31:0] VB   = 32'h8;

    logic        clk = 1'b0;
    logic        rst_n, stall, kill, is_csr, is_eret;
    logic [11:0] sel;
    logic [31:0] wval, pc;
    logic        ill, bp, ul, us;
    logic [7:0]  irq;
    logic        exc;
    logic [31:0] epc_o, vec_o, mstatus_o, mie_o, mip_o, mepc_o, mcause_o;

    always #5 clk = ~clk;

    rv_irq_ctrl #(.N_IRQ(N), .IRQ_EDGE(EDGE), .VECTOR_BASE(VB)) dut (
        .clk_i                 (clk),
        .rst_n_i               (rst_n),
        .x_stall_i             (stall),
        .x_kill_i              (kill),
        .d_is_csr_i            (is_csr),
        .d_is_eret_i           (is_eret),
        .d_csr_sel_i           (sel),
        .x_csr_write_value_i   (wval),
        .exp_invalid_insn_i    (ill),
        .exp_breakpoint_i      (bp),
        .exp_unaligned_load_i  (ul),
        .exp_unaligned_store_i (us),
        .irq_i                 (irq),
        .x_exception_pc_i      (pc),
        .x_exception_o         (exc),
        .x_exception_pc_o      (epc_o),
        .x_exception_vector_o  (vec_o),
        .csr_mstatus_o         (mstatus_o),
        .csr_mie_o             (mie_o),
        .csr_mip_o             (mip_o),
        .csr_mepc_o            (mepc_o),
        .csr_mcause_o          (mcause_o)
    );

    typedef struct {
        bit        rst;
        bit        exc;
        bit [31:0] vec, mstatus, mie, mip, mepc, mcause;
    } exp_t;

    exp_t sbq[$];
    int   checks = 0;
    int   errors = 0;

    // behavioural model state
    bit        m_trap, m_mie, m_mpie;
    bit [7:0]  m_ien, m_eip;
    bit [31:0] m_mepc, m_mcause;
    bit [7:0]  m_hist[$];   // irq samples, newest first

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h t=%0t", nm, act, expv, $time);
        end
    endtask

    task automatic model_reset();
        m_trap = 0; m_mie = 0; m_mpie = 0;
        m_ien = 0; m_eip = 0; m_mepc = 0; m_mcause = 0;
        m_hist = {8'h00, 8'h00, 8'h00};
    endtask

    function automatic int lowest_pending();
        bit [7:0] mip, pend;
        mip  = (EDGE & m_eip) | (~EDGE & m_hist[1]);
        pend = mip & m_ien;
        for (int k = 0; k < N; k++) if (pend[k]) return k;
        return -1;
    endfunction

    function automatic exp_t model_out();
        exp_t e;
        bit   sexc;
        int   low;
        bit [7:0] mip;
        mip  = (EDGE & m_eip) | (~EDGE & m_hist[1]);
        low  = lowest_pending();
        sexc = ill | bp | ul | us;
        e.rst = !rst_n;
        e.exc = rst_n && !m_trap && (sexc || (m_mie && low >= 0));
`ifdef URV_IRQ_VECTORED_EN
        e.vec = (sexc || low < 0) ? VB : VB + 32'(4 * (low + 1));
`else
        e.vec = VB;
`endif
        e.mstatus = (32'(m_mpie) << 7) | (32'(m_mie) << 3);
        e.mie     = 32'(m_ien) << 16;
        e.mip     = 32'(mip) << 16;
        e.mepc    = m_mepc;
        e.mcause  = m_mcause;
        return e;
    endfunction

    function automatic bit [31:0] model_cause();
        if (ill) return 32'd2;
        if (bp)  return 32'd3;
        if (ul)  return 32'd4;
        if (us)  return 32'd6;
        return 32'h8000_0000 | 32'(16 + lowest_pending());
    endfunction

    task automatic model_edge();
        exp_t      e;
        bit        adv;
        bit [7:0]  rise, clr;
        bit [31:0] cause;
        if (!rst_n) begin
            model_reset();
            return;
        end
        e     = model_out();
        cause = model_cause();
        adv   = !stall && !kill;
        m_hist.push_front(irq);
        void'(m_hist.pop_back());
        rise  = m_hist[1] & ~m_hist[2];
        clr   = (adv && is_csr && sel == 12'h344) ? ~wval[23:16] : 8'h00;
        m_eip = EDGE & (rise | (m_eip & ~clr));
        if (adv && is_csr && sel == 12'h304) m_ien = wval[23:16];
        if (adv && e.exc) begin
            m_mepc = pc & ~32'd3; m_mcause = cause;
            m_mpie = m_mie; m_mie = 0; m_trap = 1;
        end else if (adv && is_eret) begin
            m_mie = m_mpie; m_mpie = 1; m_trap = 0;
        end else if (adv && is_csr) begin
            case (sel)
                12'h300: begin m_mie = wval[3]; m_mpie = wval[7]; end
                12'h341: m_mepc = wval & ~32'd3;
                12'h342: m_mcause = wval;
                default: ;
            endcase
        end
    endtask

    // one cycle: push expectation for current inputs, clock, advance model
    task automatic step();
        if (!rst_n) model_reset();
        sbq.push_back(model_out());
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic idle();
        stall = 0; kill = 0; is_csr = 0; is_eret = 0;
        sel = 0; wval = 0; ill = 0; bp = 0; ul = 0; us = 0; pc = 0;
    endtask

    task automatic csr_write(input logic [11:0] a, input logic [31:0] v);
        idle(); is_csr = 1; sel = a; wval = v;
        step();
        idle();
    endtask

    task automatic rand_in();
        stall   = ($urandom_range(0, 9) < 2);
        kill    = ($urandom_range(0, 19) == 0);
        ill     = ($urandom_range(0, 39) == 0);
        bp      = ($urandom_range(0, 39) == 0);
        ul      = ($urandom_range(0, 39) == 0);
        us      = ($urandom_range(0, 39) == 0);
        is_eret = ($urandom_range(0, 11) == 0);
        is_csr  = !is_eret && ($urandom_range(0, 3) == 0);
        case ($urandom_range(0, 5))
            0: sel = 12'h300;
            1: sel = 12'h304;
            2: sel = 12'h341;
            3: sel = 12'h342;
            4: sel = 12'h344;
            default: sel = 12'($urandom_range(0, 4095));
        endcase
        wval = $urandom;
        if (sel == 12'h300) wval[3] = ($urandom_range(0, 3) != 0);
        for (int k = 0; k < N; k++)
            if ($urandom_range(0, 7) == 0) irq[k] = ~irq[k];
        pc = $urandom;
    endtask

    // monitor: compare DUT outputs with the oldest expectation
    always @(negedge clk) begin
        exp_t e;
        if (sbq.size() > 0) begin
            e = sbq.pop_front();
            chk("exc",     32'(exc),  32'(e.exc));
            chk("exc_pc",  epc_o,     e.mepc);
            chk("mstatus", mstatus_o, e.mstatus);
            chk("mie",     mie_o,     e.mie);
            chk("mip",     mip_o,     e.mip);
            chk("mepc",    mepc_o,    e.mepc);
            chk("mcause",  mcause_o,  e.mcause);
            if (e.exc || e.rst) chk("vector", vec_o, e.vec);
        end
    end

    initial begin
        idle();
        irq   = 0;
        rst_n = 0;
        model_reset();
        @(posedge clk);
        #1;
        repeat (2) step();
        rst_n = 1;

        // illegal instruction in IDLE
        idle(); ill = 1; pc = 32'h100;
        #1 chk("ill_exc", 32'(exc), 32'd1);
        step();
        idle(); bp = 1;
        #1 chk("ill_mepc", mepc_o, 32'h100);
        chk("ill_mcause", mcause_o, 32'd2);
        chk("ill_mstatus", mstatus_o, 32'h0);
        chk("bp_in_trap", 32'(exc), 32'd0);
        step();
        // stalled ERET keeps IN_TRAP, breakpoint ignored
        stall = 1; is_eret = 1;
        repeat (2) step();
        chk("stall_mcause", mcause_o, 32'd2);
        chk("stall_exc", 32'(exc), 32'd0);
        stall = 0;
        step();
        idle(); bp = 1;
        #1 chk("eret_idle_exc", 32'(exc), 32'd1);
        step();
        chk("bp_mcause", mcause_o, 32'd3);
        idle(); is_eret = 1;
        step();

        // IRQ line 3 with MIE set
        csr_write(12'h300, 32'h8);
        csr_write(12'h304, 32'h002A_0000);
        irq[3] = 1;
        step();
        chk("irq3_edge1", 32'(exc), 32'd0);
        step();
        chk("irq3_edge2", 32'(exc), 32'd1);
`ifdef URV_IRQ_VECTORED_EN
        chk("irq3_vec", vec_o, 32'h18);
`else
        chk("irq3_vec", vec_o, 32'h8);
`endif
        step();
        chk("irq3_mcause", mcause_o, 32'h8000_0013);
        irq[3] = 0;
        repeat (3) step();
        is_eret = 1; step(); idle();

        // two lines together: lowest wins, then the other
        irq[1] = 1; irq[5] = 1;
        repeat (3) step();
        chk("irq1_mcause", mcause_o, 32'h8000_0011);
        irq[1] = 0;
        repeat (3) step();
        is_eret = 1; step(); idle();
        step();
        chk("irq5_mcause", mcause_o, 32'h8000_0015);
        irq[5] = 0;
        repeat (3) step();
        is_eret = 1; step(); idle();

        // edge line 2: one-cycle pulse latches, set wins over clear
        irq[2] = 1; step();
        irq[2] = 0;
        repeat (3) step();
        chk("edge2_latched", 32'(mip_o[18]), 32'd1);
        csr_write(12'h344, 32'h0);
        chk("edge2_cleared", 32'(mip_o[18]), 32'd0);
        irq[2] = 1; step();
        irq[2] = 0;
        csr_write(12'h344, 32'h0);
        chk("edge2_set_wins", 32'(mip_o[18]), 32'd1);

        // reset in the middle of a trap
        ill = 1; pc = 32'h200; step(); idle();
        #1 rst_n = 0;
        #1;
        chk("rst_exc", 32'(exc), 32'd0);
        chk("rst_mcause", mcause_o, 32'd0);
        chk("rst_mepc", mepc_o, 32'd0);
        chk("rst_mip", mip_o, 32'd0);
        chk("rst_vec", vec_o, 32'h8);
        repeat (2) step();
        rst_n = 1;

        // randomized traffic
        for (int i = 0; i < 3000; i++) begin
            rand_in();
            step();
        end

        idle();
        repeat (2) step();
        for (int i = 0; i < 10 && sbq.size() > 0; i++) @(negedge clk);
        #1;
        if (sbq.size() != 0) begin
            errors++;
            $display("FAIL drain actual=%0d expected=0", sbq.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/rv_irq_ctrl.md
RV_IRQ_CTRL -- requirements
Module: rv_irq_ctrl

Interface
REQ-001 SHALL have parameter N_IRQ, default 8: number of external interrupt lines, legal range 1..16.
REQ-002 SHALL have parameter IRQ_EDGE, default 0 (N_IRQ bits): bit k=1 makes line k edge-triggered, bit k=0 makes it level-triggered.
REQ-003 SHALL have parameter VECTOR_BASE, default 32'h8: trap vector base address.
REQ-004 SHALL have ports: clk_i in 1, the single clock; rst_n_i in 1, asynchronous active-low reset.
REQ-005 SHALL have pipeline control ports: x_stall_i in 1, execute stall; x_kill_i in 1, execute kill.
REQ-006 SHALL have decode ports: d_is_csr_i in 1, CSR access; d_is_eret_i in 1, ERET; d_csr_sel_i in 12, CSR address; x_csr_write_value_i in 32, CSR write data.
REQ-007 SHALL have synchronous exception inputs exp_invalid_insn_i, exp_breakpoint_i, exp_unaligned_load_i and exp_unaligned_store_i, each in 1.
REQ-008 SHALL have trap ports: irq_i in N_IRQ, asynchronous interrupt lines; x_exception_pc_i in 32, PC of the faulting instruction.
REQ-009 SHALL have outputs x_exception_o out 1, trap request; x_exception_pc_o out 32, equal to mepc; x_exception_vector_o out 32, trap target.
REQ-010 SHALL have outputs csr_mstatus_o, csr_mie_o, csr_mip_o, csr_mepc_o and csr_mcause_o, each out 32.

Function
REQ-011 SHALL implement a two-state FSM, IDLE and IN_TRAP; all state updates SHALL occur only on cycles with !x_stall_i && !x_kill_i ("advance").
REQ-012 SHALL define trap_req = any sync exception input OR (mstatus.MIE && |(mip & mie)).
REQ-013 SHALL drive x_exception_o = (state==IDLE) && trap_req, combinationally.
REQ-014 On advance with x_exception_o=1, SHALL set mepc<=x_exception_pc_i, mcause<=cause, MPIE<=MIE, MIE<=0, state<=IN_TRAP.
REQ-015 Cause priority SHALL be: illegal (2) > breakpoint (3) > unaligned load (4) > unaligned store (6) > IRQ k with the lowest k first; an IRQ k cause SHALL be {1'b1, 31'd16+k}.
REQ-016 Sync exceptions in IN_TRAP SHALL be ignored: no mepc/mcause update, x_exception_o=0.
REQ-017 ERET on advance SHALL set MIE<=MPIE, MPIE<=1 and state<=IDLE, in either state; a new trap SHALL NOT be taken before the next cycle.
REQ-018 Each irq_i line SHALL pass a 2-flop synchronizer; a mip bit SHALL set 2 rising edges after the input rises.
REQ-019 A level mip bit SHALL follow the synchronized line; an edge mip bit SHALL latch on a synchronized 0->1 transition and clear on an advance CSR write to MIP with that bit at 0; a simultaneous set SHALL win.
REQ-020 mip/mie bit 16+k SHALL correspond to line k; all other mip/mie bits SHALL read 0; bits of MIP writes for level lines SHALL be ignored.
REQ-021 CSR writes on advance SHALL update: MSTATUS (bits 3 MIE, 7 MPIE), MIE (bits 16..16+N_IRQ-1), MEPC (bits 31:2; bits 1:0 read 0), MCAUSE (full 32 bits).
REQ-022 If a trap and a CSR write occur on the same advance, the trap SHALL win for mepc, mcause and mstatus.
REQ-023 Interrupt synchronization and edge latching SHALL continue during stall and kill.

Reset
REQ-024 On rst_n_i=0, asynchronously: state=IDLE, mepc=0, mcause=0, MIE=0, MPIE=0, mie=0, mip=0, synchronizer flops=0.
REQ-025 During reset, x_exception_o=0, x_exception_vector_o=VECTOR_BASE and all csr_*_o=0; reset mid-trap SHALL return the block to IDLE.

Configuration
REQ-026 With URV_IRQ_VECTORED_EN defined, interrupt k SHALL vector to VECTOR_BASE+4*(k+1) and sync exceptions to VECTOR_BASE.
REQ-027 Without URV_IRQ_VECTORED_EN, every trap SHALL vector to VECTOR_BASE.

Structure
REQ-028 CSR addresses (MSTATUS 0x300, MIE 0x304, MEPC 0x341, MCAUSE 0x342, MIP 0x344), cause codes and mstatus bit positions SHALL live in rv_defs.
REQ-029 SHALL instantiate sub-module rv_irq_sync, a vectorised N_IRQ-wide 2-flop synchronizer with rising-edge detector.

Verification
REQ-030 Illegal instruction with PC=0x100 in IDLE -> x_exception_o=1 that cycle; mepc=0x100, mcause=2, MIE=0, state IN_TRAP.
REQ-031 MIE=1, mie bit 19 set, irq_i[3] rises -> x_exception_o on the 2nd edge; mcause=0x80000013; vector 0x18 (vectored) or 0x8 (not vectored).
REQ-032 irq_i[1] and irq_i[5] rise together with both enabled -> mcause=0x80000011; after ERET with line 1 deasserted, mcause=0x80000015.
REQ-033 Edge line 2 pulses for 1 cycle -> mip bit 18 stays set; a MIP write of 0 in the same cycle as a new edge -> bit stays 1.
REQ-034 Breakpoint during IN_TRAP, then x_stall_i=1 with ERET -> no mcause change; ERET held under stall leaves IN_TRAP unchanged until stall drops.
REQ-035 rst_n_i low mid-trap -> all outputs 0 immediately; vector = 0x8.
